// File: rtl/led_stream_pkg.sv
// Shared sizes and state encodings for the LED frame streamer and its channel transmitters.
package led_stream_pkg;

  localparam int unsigned GRID_BITS    = 256;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned BYTES_PER_CH = GRID_BITS / (2 * BYTE_W);
  localparam int unsigned IDX_W        = $clog2(BYTES_PER_CH);

  typedef enum logic [1:0] {
    TOP_IDLE   = 2'd0,
    TOP_STREAM = 2'd1,
    TOP_DONE   = 2'd2,
    TOP_ABORT  = 2'd3
  } top_state_e;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_SEND = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/led_channel_tx.sv
// One LED driver channel: synchronizes the Arduino acknowledge clock, steps through
// the bytes of its half-frame on each rising edge, and watches for a stalled receiver.
module led_channel_tx
  import led_stream_pkg::*;
#(
  parameter int unsigned BYTES          = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ack_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [BYTES*BYTE_W-1:0]   slice_i,
  output logic [BYTE_W-1:0]         data_o,
  output logic                      start_o,
  output logic                      done_o,
  output logic                      timed_out_o
);

  localparam int unsigned IDX_BITS = $clog2(BYTES);
  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_LAST  = TIMEOUT_CYCLES - 1;

  ch_state_e               state_q, state_d;
  logic [IDX_BITS-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]        wd_q, wd_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    prev_q;
  logic [BYTE_W-1:0]       data_q, data_d;
  logic                    start_q, start_d;
  logic                    timed_out_q, timed_out_d;
  logic                    rise_c;

  // Edge detection runs regardless of channel state; only SEND consumes it.
  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      state_q     <= CH_IDLE;
      idx_q       <= '0;
      wd_q        <= '0;
      data_q      <= '0;
      start_q     <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ack_i};
      prev_q      <= sync_q[SYNC_STAGES-1];
      state_q     <= state_d;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      data_q      <= data_d;
      start_q     <= start_d;
      timed_out_q <= timed_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wd_d    = wd_q;

    if (abort_i) begin
      state_d = CH_IDLE;
      idx_d   = '0;
      wd_d    = '0;
    end else if (start_i) begin
      state_d = CH_SEND;
      idx_d   = '0;
      wd_d    = '0;
    end else if (state_q == CH_SEND) begin
      if (rise_c) begin
        wd_d = '0;
        if (idx_q == IDX_BITS'(BYTES - 1)) begin
          state_d = CH_DONE;
        end else begin
          idx_d = idx_q + IDX_BITS'(1);
        end
      end else if (wd_q != CNT_W'(WD_LAST)) begin
        wd_d = wd_q + CNT_W'(1);
      end
    end

    // Outputs are registered from next-state so the byte lands with the index update.
    start_d     = (state_d == CH_SEND);
    data_d      = start_d ? slice_i[{idx_d, 3'b000} +: BYTE_W] : '0;
    // Flag one cycle early so the top-level abort lands TIMEOUT_CYCLES after the last accepted edge.
    timed_out_d = start_d && (wd_d == CNT_W'(WD_LAST));
  end

  assign data_o      = data_q;
  assign start_o     = start_q;
  assign done_o      = (state_q == CH_DONE);
  assign timed_out_o = timed_out_q;

endmodule

// File: rtl/led_frame_streamer.sv
// Captures a 256-bit frame on load and streams its two halves to two Arduino LED
// drivers, reporting completion or a receiver timeout with one-cycle pulses.
module led_frame_streamer #(
  parameter int unsigned GRID_BITS      = led_stream_pkg::GRID_BITS,
  parameter int unsigned BYTES_PER_CH   = led_stream_pkg::BYTES_PER_CH,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [GRID_BITS-1:0] grid_in,
  input  logic                 arduinoClock,
  input  logic                 arduinoClock2,
  output logic [7:0]           ledOut,
  output logic [7:0]           ledOut2,
  output logic                 arduinoStart,
  output logic                 arduinoStart2,
  output logic                 busy,
  output logic                 finished,
  output logic                 timeout
);

  import led_stream_pkg::*;

  localparam int unsigned HALF = GRID_BITS / 2;

  top_state_e           state_q, state_d;
  logic [GRID_BITS-1:0] frame_q, frame_d;
  logic                 busy_q, finished_q, timeout_q;
  logic                 load_acc_c, abort_c;
  logic                 done0, done1, to0, to1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= TOP_IDLE;
      frame_q    <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      busy_q     <= (state_d == TOP_STREAM);
      finished_q <= (state_d == TOP_DONE);
      timeout_q  <= (state_d == TOP_ABORT);
    end
  end

  // Loads are honoured only from IDLE; the frame register is otherwise frozen.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    load_acc_c = 1'b0;
    unique case (state_q)
      TOP_IDLE: begin
        if (load) begin
          load_acc_c = 1'b1;
          frame_d    = grid_in;
          state_d    = TOP_STREAM;
        end
      end
      TOP_STREAM: begin
        if (done0 && done1) begin
          state_d = TOP_DONE;
        end else if (to0 || to1) begin
          state_d = TOP_ABORT;
        end
      end
      TOP_DONE:  state_d = TOP_IDLE;
      TOP_ABORT: state_d = TOP_IDLE;
      default:   state_d = TOP_IDLE;
    endcase
    abort_c = (state_d == TOP_ABORT);
  end

  led_channel_tx #(
    .BYTES          (BYTES_PER_CH),
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_ch0 (
    .clk_i       (clock),
    .rst_i       (reset),
    .ack_i       (arduinoClock),
    .start_i     (load_acc_c),
    .abort_i     (abort_c),
    .slice_i     (frame_d[HALF-1:0]),
    .data_o      (ledOut),
    .start_o     (arduinoStart),
    .done_o      (done0),
    .timed_out_o (to0)
  );

  led_channel_tx #(
    .BYTES          (BYTES_PER_CH),
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_ch1 (
    .clk_i       (clock),
    .rst_i       (reset),
    .ack_i       (arduinoClock2),
    .start_i     (load_acc_c),
    .abort_i     (abort_c),
    .slice_i     (frame_d[GRID_BITS-1:HALF]),
    .data_o      (ledOut2),
    .start_o     (arduinoStart2),
    .done_o      (done1),
    .timed_out_o (to1)
  );

  assign busy     = busy_q;
  assign finished = finished_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_led_frame_streamer.sv
// Self-checking bench for led_frame_streamer: byte scoreboard per channel plus
// table-driven acknowledge sequences and hand-written corner cases.
module tb_led_frame_streamer;

  localparam int unsigned TO = 100;

  logic         clock = 1'b0;
  logic         reset, load, arduinoClock, arduinoClock2;
  logic [255:0] grid_in;
  logic [7:0]   ledOut, ledOut2;
  logic         arduinoStart, arduinoStart2, busy, finished, timeout;

  led_frame_streamer #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .grid_in       (grid_in),
    .arduinoClock  (arduinoClock),
    .arduinoClock2 (arduinoClock2),
    .ledOut        (ledOut),
    .ledOut2       (ledOut2),
    .arduinoStart  (arduinoStart),
    .arduinoStart2 (arduinoStart2),
    .busy          (busy),
    .finished      (finished),
    .timeout       (timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit a0;
    bit a1;
    bit st0;
    bit st1;
    bit bsy;
    int fin;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fin_cnt = 0;
  int to_cnt = 0;
  int t_last1 = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (finished === 1'b1) fin_cnt <= fin_cnt + 1;
    if (timeout === 1'b1)  to_cnt  <= to_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [255:0] f, input int ch, input int k);
    return f[ch*128 + k*8 +: 8];
  endfunction

  task automatic check_ch(input string nm);
    if (q0.size() > 0) begin
      chk({nm, "_st0"}, 32'(arduinoStart), 32'd1);
      chk({nm, "_led0"}, 32'(ledOut), 32'(q0[0]));
    end else begin
      chk({nm, "_st0"}, 32'(arduinoStart), 32'd0);
      chk({nm, "_led0"}, 32'(ledOut), 32'd0);
    end
    if (q1.size() > 0) begin
      chk({nm, "_st1"}, 32'(arduinoStart2), 32'd1);
      chk({nm, "_led1"}, 32'(ledOut2), 32'(q1[0]));
    end else begin
      chk({nm, "_st1"}, 32'(arduinoStart2), 32'd0);
      chk({nm, "_led1"}, 32'(ledOut2), 32'd0);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_led0"}, 32'(ledOut), 32'd0);
    chk({nm, "_led1"}, 32'(ledOut2), 32'd0);
    chk({nm, "_st0"}, 32'(arduinoStart), 32'd0);
    chk({nm, "_st1"}, 32'(arduinoStart2), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_fin"}, 32'(finished), 32'd0);
  endtask

  // Scoreboard fill: the expected byte stream of both channels for a fresh frame.
  task automatic do_load(input logic [255:0] g);
    grid_in = g;
    load = 1'b1;
    tick();
    load = 1'b0;
    q0.delete();
    q1.delete();
    for (int k = 0; k < 16; k++) begin
      q0.push_back(byte_of(g, 0, k));
      q1.push_back(byte_of(g, 1, k));
    end
  endtask

  // Rising edge on the selected lines: old byte still out 2 cycles later, new byte at 3.
  task automatic ack(input bit a0, input bit a1);
    if (a0) arduinoClock = 1'b1;
    if (a1) arduinoClock2 = 1'b1;
    tick();
    tick();
    check_ch("pre_edge");
    tick();
    if (a0 && q0.size() > 0) void'(q0.pop_front());
    if (a1 && q1.size() > 0) begin
      void'(q1.pop_front());
      t_last1 = cyc;
    end
    check_ch("post_edge");
    arduinoClock = 1'b0;
    arduinoClock2 = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic run_table(input string nm);
    int base;
    base = fin_cnt;
    for (int i = 0; i < vecs.size(); i++) begin
      ack(vecs[i].a0, vecs[i].a1);
      chk({nm, "_st0"}, 32'(arduinoStart), 32'(vecs[i].st0));
      chk({nm, "_st1"}, 32'(arduinoStart2), 32'(vecs[i].st1));
      chk({nm, "_busy"}, 32'(busy), 32'(vecs[i].bsy));
      chk({nm, "_fin_count"}, 32'(fin_cnt - base), 32'(vecs[i].fin));
    end
  endtask

  initial begin
    logic [255:0] f;
    logic [255:0] g;
    int fb;
    int tb;
    int t_to;
    vec_t v;

    reset = 1'b1;
    load = 1'b0;
    arduinoClock = 1'b0;
    arduinoClock2 = 1'b0;
    grid_in = '0;
    tick();
    tick();
    check_zero("reset");
    chk("reset_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    tick();

    // Full frame, both channels acknowledged together.
    f = {4{64'h0123456789ABCDEF}};
    do_load(f);
    check_ch("load1");
    chk("load1_busy", 32'(busy), 32'd1);
    chk("load1_byte0", 32'(ledOut), 32'hEF);
    vecs.delete();
    for (int i = 0; i < 16; i++) begin
      v.a0 = 1; v.a1 = 1; v.st0 = (i < 15); v.st1 = (i < 15);
      v.bsy = (i < 15); v.fin = (i == 15) ? 1 : 0;
      vecs.push_back(v);
    end
    tb = to_cnt;
    run_table("full");
    chk("full_no_timeout", 32'(to_cnt - tb), 32'd0);

    // Channel 1 lags channel 0 by ten bytes.
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
    do_load(f);
    check_ch("load2");
    vecs.delete();
    for (int i = 0; i < 26; i++) begin
      v.a0 = (i < 16); v.a1 = (i < 6) || (i >= 16);
      v.st0 = (i < 15); v.st1 = (i < 25); v.bsy = (i < 25);
      v.fin = (i == 25) ? 1 : 0;
      vecs.push_back(v);
    end
    run_table("lag");

    // Acknowledge line already high at load must first fall.
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
    arduinoClock = 1'b1;
    repeat (6) tick();
    do_load(f);
    repeat (10) tick();
    check_ch("held_high");
    chk("held_high_byte0", 32'(ledOut), 32'(byte_of(f, 0, 0)));
    arduinoClock = 1'b0;
    repeat (3) tick();
    check_ch("held_low");
    ack(1, 0);
    chk("held_then_edge", 32'(ledOut), 32'(byte_of(f, 0, 1)));

    // Load while busy is ignored; stream continues from the first frame.
    fb = fin_cnt;
    grid_in = ~f;
    load = 1'b1;
    tick();
    load = 1'b0;
    check_ch("busy_load");
    for (int i = 0; i < 40 && (q0.size() > 0 || q1.size() > 0); i++)
      ack(q0.size() > 0, q1.size() > 0);
    chk("busy_load_fin", 32'(fin_cnt - fb), 32'd1);
    chk("busy_load_idle", 32'(busy), 32'd0);

    // Channel 1 stalls after five bytes: watchdog abort.
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
    fb = fin_cnt;
    tb = to_cnt;
    do_load(f);
    for (int i = 0; i < 5; i++) ack(1, 1);
    while (q0.size() > 0) ack(1, 0);
    for (int i = 0; i < 3 * TO && timeout !== 1'b1; i++) tick();
    t_to = cyc;
    chk("timeout_seen", 32'(timeout), 32'd1);
    chk("timeout_delay", 32'(t_to - t_last1), 32'(TO));
    check_zero("abort");
    tick();
    chk("timeout_pulse_len", 32'(timeout), 32'd0);
    chk("abort_no_fin", 32'(fin_cnt - fb), 32'd0);
    chk("abort_one_timeout", 32'(to_cnt - tb), 32'd1);
    q0.delete();
    q1.delete();

    // Reset mid-frame, then reset beating a simultaneous load.
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
    do_load(f);
    for (int i = 0; i < 8; i++) ack(1, 1);
    chk("pre_reset_byte8", 32'(ledOut2), 32'(byte_of(f, 1, 8)));
    reset = 1'b1;
    tick();
    check_zero("mid_reset");
    grid_in = ~f;
    load = 1'b1;
    tick();
    load = 1'b0;
    reset = 1'b0;
    chk("reset_beats_load", 32'(busy), 32'd0);
    tick();
    do_load(f);
    check_ch("restart");
    chk("restart_byte0", 32'(ledOut), 32'(byte_of(f, 0, 0)));

    // Load in the finished cycle is dropped; the following cycle is accepted.
    for (int i = 0; i < 15; i++) ack(1, 1);
    arduinoClock = 1'b1;
    arduinoClock2 = 1'b1;
    for (int i = 0; i < 10 && finished !== 1'b1; i++) tick();
    chk("fin_pulse", 32'(finished), 32'd1);
    g = ~f;
    grid_in = g;
    load = 1'b1;
    tick();
    chk("load_in_done_ignored", 32'(busy), 32'd0);
    tick();
    load = 1'b0;
    chk("load_after_done_busy", 32'(busy), 32'd1);
    chk("load_after_done_byte0", 32'(ledOut2), 32'(byte_of(g, 1, 0)));
    arduinoClock = 1'b0;
    arduinoClock2 = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
